// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared instruction constants for the fetch path
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam int          PC_BYTE_BITS = 2;

  // Pointer width that stays legal for single-entry buffers.
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - small circular FIFO holding fetched {pc, inst} entries
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter  int WIDTH = 44,
  parameter  int DEPTH = 2,
  localparam int PTR_W = ptr_width(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop & ~empty;
  // A full buffer still accepts a write when the head leaves on the same edge.
  assign do_push   = push & (~full | do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  no_overflow_a: assert property (@(posedge CLK) disable iff (!RESET_N)
    !(push && full && !do_pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end driving a registered ROM
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 10,
  parameter int DEPTH     = 2
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [ADDR_SIZE+1:0] redirect_pc,
  output logic [ADDR_SIZE-1:0] iaddr,
  input  logic [DATA_SIZE-1:0] idata,
  output logic [DATA_SIZE-1:0] inst_if,
  output logic [ADDR_SIZE+1:0] pc_if,
  output logic                 valid_if
);

  localparam int PC_W    = ADDR_SIZE + 2;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int OCC_W   = CNT_W + 1;
  localparam int ENTRY_W = PC_W + DATA_SIZE;

  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    inflight_pc;
  logic [PC_W-1:0]    target_pc;
  logic               inflight;
  logic               pop;
  logic               issue;
  logic               push;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  logic [OCC_W-1:0]   occupancy;
  logic [ENTRY_W-1:0] head;

  assign target_pc = redirect_pc & ~PC_W'(3);
  assign occupancy = {1'b0, count} + OCC_W'(inflight);

  // Outstanding ROM reads are reserved buffer slots, so the buffer can never overflow.
  assign pop   = ~empty & ~stall & ~redirect;
  assign issue = ~redirect & ((occupancy < OCC_W'(DEPTH)) |
                              ((occupancy == OCC_W'(DEPTH)) & pop));
  assign push  = inflight & ~redirect;
  assign iaddr = redirect ? target_pc[PC_W-1:PC_BYTE_BITS] : fetch_pc[PC_W-1:PC_BYTE_BITS];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc    <= target_pc + PC_W'(4);
      inflight    <= 1'b1;
      inflight_pc <= target_pc;
    end else if (issue) begin
      fetch_pc    <= fetch_pc + PC_W'(4);
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  fetch_buffer #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fetch_buffer (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .flush     (redirect),
    .push      (push),
    .push_data ({inflight_pc, idata}),
    .pop       (pop),
    .head_data (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign valid_if = ~empty;
  assign inst_if  = empty ? DATA_SIZE'(NOP_INST) : head[DATA_SIZE-1:0];
  assign pc_if    = empty ? '0 : head[ENTRY_W-1:DATA_SIZE];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against an instruction-stream model
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int DATA_SIZE = 32;
  localparam int ADDR_SIZE = 10;
  localparam int DEPTH     = 2;
  localparam int PC_W      = ADDR_SIZE + 2;

  logic                 CLK         = 1'b0;
  logic                 RESET_N     = 1'b1;
  logic                 stall       = 1'b0;
  logic                 redirect    = 1'b0;
  logic [PC_W-1:0]      redirect_pc = '0;
  logic [ADDR_SIZE-1:0] iaddr;
  logic [DATA_SIZE-1:0] idata;
  logic [DATA_SIZE-1:0] inst_if;
  logic [PC_W-1:0]      pc_if;
  logic                 valid_if;

  logic [DATA_SIZE-1:0] rom [1 << ADDR_SIZE];

  int              checks = 0;
  int              errors = 0;
  logic [PC_W-1:0] exp_pc = '0;
  int              since  = 0;

  fetch_unit #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE),
    .DEPTH     (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .iaddr       (iaddr),
    .idata       (idata),
    .inst_if     (inst_if),
    .pc_if       (pc_if),
    .valid_if    (valid_if)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) idata <= rom[iaddr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: apply inputs after the falling edge, then compare the presented
  // instruction with the next one the program stream says must be accepted.
  task automatic step(input logic s, input logic r, input logic [PC_W-1:0] rpc);
    @(negedge CLK);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    since++;
    #1;
    if (r) begin
      chk("redirect_iaddr", 64'(iaddr), 64'(rpc[PC_W-1:2]));
      exp_pc = rpc & ~12'h003;
      since  = 0;
    end else if (since < 2) begin
      chk("startup_valid", 64'(valid_if), 64'(1'b0));
      chk("startup_inst", 64'(inst_if), 64'(NOP_INST));
      chk("startup_pc", 64'(pc_if), 64'(12'h000));
    end else begin
      chk("stream_valid", 64'(valid_if), 64'(1'b1));
      if (valid_if) begin
        chk("stream_pc", 64'(pc_if), 64'(exp_pc));
        chk("stream_inst", 64'(inst_if), 64'(rom[exp_pc[PC_W-1:2]]));
        if (!s) exp_pc = exp_pc + 12'd4;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    RESET_N     = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    #1;
    chk("reset_valid", 64'(valid_if), 64'(1'b0));
    chk("reset_inst", 64'(inst_if), 64'(NOP_INST));
    chk("reset_pc", 64'(pc_if), 64'(12'h000));
    chk("reset_iaddr", 64'(iaddr), 64'(10'h000));
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    since   = 0;
    exp_pc  = '0;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_SIZE); i++) rom[i] = i;

    // Straight-line fetch from reset: pc 0,4,8,... with inst 0,1,2,...
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 12'h000);

    // Stall five cycles with 0x010 at the head, then resume.
    do_reset();
    for (int i = 0; i < 20 && exp_pc != 12'h010; i++) step(1'b0, 1'b0, 12'h000);
    chk("reach_0x010", 64'(exp_pc), 64'(12'h010));
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 12'h000);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 12'h000);

    // Fill the buffer, then redirect to 0x200.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 12'h000);
    step(1'b0, 1'b1, 12'h200);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 12'h000);

    // Redirect wins over stall; misaligned target is truncated to 0x100.
    step(1'b1, 1'b1, 12'h102);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 12'h000);

    // Address wrap 0xFF8, 0xFFC, 0x000.
    step(1'b0, 1'b1, 12'hFF8);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 12'h000);

    // Reset mid-stream and restart at 0.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 12'h000);

    // Random program image with random stalls and redirects.
    for (int i = 0; i < (1 << ADDR_SIZE); i++) rom[i] = $urandom;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step((($urandom % 10) < 3), (($urandom % 20) == 0), PC_W'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_SIZE, 32, instruction width.
REQ-002 Parameter ADDR_SIZE, 10, ROM word-address width; byte PC width is ADDR_SIZE+2.
REQ-003 Parameter DEPTH, 2, instruction buffer entries.
REQ-004 CLK  input  1  single clock, all state on rising edge.
REQ-005 RESET_N  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  downstream cannot accept (hazard-unit hold).
REQ-007 redirect  input  1  taken branch/jump; flush and restart fetch.
REQ-008 redirect_pc  input  ADDR_SIZE+2  byte target address.
REQ-009 iaddr  output  ADDR_SIZE  word address to registered instruction ROM.
REQ-010 idata  input  DATA_SIZE  ROM data, valid the cycle after iaddr.
REQ-011 inst_if  output  DATA_SIZE  instruction presented to IF/ID register.
REQ-012 pc_if  output  ADDR_SIZE+2  byte PC of inst_if.
REQ-013 valid_if  output  1  inst_if/pc_if hold a real instruction.

Function
REQ-014 Internal state: fetch_pc (ADDR_SIZE+2), in-flight flag plus in-flight PC, DEPTH-entry FIFO of {pc, inst}, occupancy count.
REQ-015 pop = valid_if AND NOT stall AND NOT redirect; FIFO head removed on that edge.
REQ-016 issue (no redirect) when count + inflight < DEPTH, or when count + inflight = DEPTH and pop is 1; yields one instruction per cycle in steady state.
REQ-017 On issue: iaddr = fetch_pc[ADDR_SIZE+1:2]; at the edge, inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4.
REQ-018 No issue: iaddr = fetch_pc[ADDR_SIZE+1:2], fetch_pc holds, inflight <= 0.
REQ-019 Cycle with inflight = 1: {inflight_pc, idata} written into the FIFO at the edge, unless redirect is 1.
REQ-020 Outputs driven from FIFO head: valid_if = (count != 0); when empty, inst_if = NOP (32'h00000013), pc_if = 0.
REQ-021 redirect = 1: FIFO flushed, in-flight response discarded, iaddr = redirect_pc[ADDR_SIZE+1:2] that cycle, inflight <= 1, inflight_pc <= redirect_pc, fetch_pc <= redirect_pc + 4.
REQ-022 Redirect priority: redirect overrides stall, pop, and normal issue in the same cycle.
REQ-023 redirect_pc[1:0] ignored (treated as 00); pc_if[1:0] always 00.
REQ-024 Latency: redirect in cycle t -> valid_if = 1 with pc_if = redirect_pc in cycle t+2.
REQ-025 fetch_pc wraps modulo 2^(ADDR_SIZE+2): 0xFFC + 4 -> 0x000 at defaults.
REQ-026 stall held indefinitely: FIFO fills to DEPTH, issue stops, no instruction lost or duplicated; outputs stable.
REQ-027 Simultaneous write and pop at count = DEPTH: legal, count unchanged, order preserved.
REQ-028 FIFO never overflows; write when full is a design error (assertion).

Reset
REQ-029 RESET_N low: fetch_pc = 0, inflight = 0, FIFO empty, valid_if = 0, inst_if = NOP, pc_if = 0, iaddr = 0, immediately and asynchronously.
REQ-030 Reset mid-operation discards in-flight and buffered instructions; first issue is PC 0 in the first cycle after RESET_N rises; valid_if rises in the second cycle.

Structure
REQ-031 NOP encoding constant lives in the shared control/instruction-type package, not local to this module.
REQ-032 FIFO is one sub-module, fetch_buffer (parameter DEPTH, synchronous flush, push/pop/full/empty); pointer wrap handled inside it.
REQ-033 No combinational path from idata to inst_if; the only combinational input-to-output paths are redirect/redirect_pc/stall to iaddr.

Verification
REQ-034 Reset release, stall = 0, ROM[i] = i -> valid_if in cycle 2, pc_if 0,4,8,... back-to-back with inst_if 0,1,2,...
REQ-035 stall high 5 cycles at pc_if = 0x010 -> pc_if/inst_if held; after release, sequence resumes 0x010, 0x014, with no gap beyond one cycle and no duplicate.
REQ-036 redirect to 0x200 while FIFO full -> buffered entries dropped; cycle t+2 pc_if = 0x200, then 0x204.
REQ-037 redirect and stall both high -> redirect taken; redirect_pc = 0x102 -> pc_if = 0x100.
REQ-038 Sequential fetch from 0xFF8 -> pc_if 0xFF8, 0xFFC, 0x000.
REQ-039 RESET_N pulsed low mid-stream -> valid_if = 0 and inst_if = NOP asynchronously; restart at PC 0.
